// File: rtl/mau_pkg.sv
// Shared types and lane helpers for the load/store front end (mem_access_unit).
// Sub-word support is selected by the MAU_SUBWORD_EN macro.
package mau_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        RESP = 2'b11
    } state_t;

    // Replace the addressed byte/half of old_word with the low store data (little-endian lanes).
    function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                               input logic [15:0] st_data,
                                               input logic [1:0]  off,
                                               input size_t       size);
        logic [31:0] w;
        w = old_word;
        if (size == SZ_BYTE)
            w[{off, 3'b000} +: 8] = st_data[7:0];
        else if (size == SZ_HALF)
            w[{off[1], 4'b0000} +: 16] = st_data;
        return w;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  off,
                                                input size_t       size,
                                                input logic        uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
            SZ_HALF: r = uns ? {16'h0000, h}   : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mau_if.sv
// Pipeline request/response and data-memory port bundle for mem_access_unit.
interface mau_if;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    // master = pipeline plus memory; slave = the access unit itself
    modport master (
        output req, we, size, uns, addr, wdata, mem_rd,
        input  busy, done, err, rdata, mem_read, mem_write, mem_addr, mem_wd
    );

    modport slave (
        input  req, we, size, uns, addr, wdata, mem_rd,
        output busy, done, err, rdata, mem_read, mem_write, mem_addr, mem_wd
    );
endinterface

// File: rtl/mau_lane.sv
// Combinational store-merge and load-extend datapath for sub-word accesses.
module mau_lane
    import mau_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [15:0] st_data,
    input  logic [1:0]  off,
    input  size_t       size,
    input  logic        uns,
    output logic [31:0] merged,
    output logic [31:0] loaded
);
    assign merged = lane_merge(old_word, st_data, off, size);
    assign loaded = load_extend(old_word, off, size, uns);
endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end: turns one request into word-aligned RD/WR memory cycles.
// Define MAU_SUBWORD_EN to enable byte/half accesses; otherwise only aligned words are legal.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 1024
)(
    input  logic clk,
    input  logic rst_n,
    mau_if.slave bus
);
    state_t      state_q, state_d;
    logic        accept, illegal, out_of_range;
    logic        we_q, err_q;
    logic [31:0] rdata_q, mem_addr_q, mem_wd_q;
    logic [31:0] rd_word, wr_word;

    assign accept       = bus.req && (state_q == IDLE);
    assign out_of_range = bus.addr > (MEM_BYTES - 32'd4);

`ifdef MAU_SUBWORD_EN
    size_t      size_q;
    logic [1:0] off_q;
    logic       uns_q;

    assign illegal = (bus.size == SZ_RSVD)
                  || (bus.size == SZ_HALF && bus.addr[0])
                  || (bus.size == SZ_WORD && bus.addr[1:0] != 2'b00)
                  || out_of_range;

    always_ff @(posedge clk) begin
        if (accept) begin
            size_q <= size_t'(bus.size);
            off_q  <= bus.addr[1:0];
            uns_q  <= bus.uns;
        end
    end

    // mem_wd_q holds the raw store data until the old word arrives in RD
    mau_lane u_lane (
        .old_word (bus.mem_rd),
        .st_data  (mem_wd_q[15:0]),
        .off      (off_q),
        .size     (size_q),
        .uns      (uns_q),
        .merged   (wr_word),
        .loaded   (rd_word)
    );
`else
    assign illegal = (bus.size != SZ_WORD) || (bus.addr[1:0] != 2'b00) || out_of_range;
    assign rd_word = bus.mem_rd;
    assign wr_word = mem_wd_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) begin
                if (illegal)                           state_d = RESP;
                else if (bus.we && bus.size == SZ_WORD) state_d = WR;
                else                                   state_d = RD;
            end
            RD:      state_d = we_q ? WR : RESP;
            WR:      state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy      = (state_q != IDLE);
        bus.mem_read  = (state_q == RD);
        bus.mem_write = (state_q == WR);
        bus.done      = (state_q == RESP);
        bus.err       = (state_q == RESP) && err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            mem_addr_q <= '0;
            mem_wd_q   <= '0;
        end else begin
            if (accept) begin
                we_q       <= bus.we;
                err_q      <= illegal;
                mem_addr_q <= {bus.addr[31:2], 2'b00};
                mem_wd_q   <= bus.wdata;
            end
            if (state_q == RD) begin
                if (we_q) mem_wd_q <= wr_word;
                else      rdata_q  <= rd_word;
            end
        end
    end

    assign bus.rdata    = rdata_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_wd   = mem_wd_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit against a byte-array reference model.
module tb_mem_access_unit;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          nrd;
        int          nwr;
        int          ndone;
        logic [31:0] wd;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mau_if mif ();

    mem_access_unit #(.MEM_BYTES(1024)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (mif)
    );

    logic [31:0] mem [256];
    logic [7:0]  ref_b [1024];
    logic [31:0] exp_rdata;
    int          nvec = 0;
    int          nmis = 0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          done_cnt = 0;
    logic [31:0] last_wd = '0;
    logic        pre_we;
    logic [7:0]  pre_idx;
    logic [31:0] pre_data;

    assign mif.mem_rd = mem[mif.mem_addr[9:2]];

    always @(posedge clk) begin
        if (pre_we)
            mem[pre_idx] <= pre_data;
        else if (mif.mem_write) begin
            mem[mif.mem_addr[9:2]] <= mif.mem_wd;
            last_wd <= mif.mem_wd;
        end
        if (mif.mem_write) wr_cnt <= wr_cnt + 1;
        if (mif.mem_read)  rd_cnt <= rd_cnt + 1;
        if (mif.done)      done_cnt <= done_cnt + 1;
    end

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {ref_b[a+3], ref_b[a+2], ref_b[a+1], ref_b[a]};
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("err=%0b rdata=%h lat=%0d rd=%0d wr=%0d done=%0d wd=%h",
                         o.err, o.rdata, o.lat, o.nrd, o.nwr, o.ndone, o.wd);
    endfunction

    // Reference: legality from the rules, data from the byte image.
    function automatic obs_t model(input bit we, input bit [1:0] sz, input bit u,
                                   input bit [31:0] a, input bit [31:0] wd);
        obs_t        e;
        int          nb;
        bit          ok;
        logic [31:0] v;
        nb = 1 << sz;
        ok = (sz != 2'd3) && (a <= 32'd1020) && ((a % 32'(nb)) == 0);
`ifndef MAU_SUBWORD_EN
        ok = ok && (sz == 2'd2);
`endif
        e.ndone = 1; e.nrd = 0; e.nwr = 0; e.wd = '0; e.err = 1'b0;
        if (!ok) begin
            e.err = 1'b1;
            e.lat = 1;
        end else if (!we) begin
            v = '0;
            for (int i = 0; i < nb; i++) v |= 32'(ref_b[a+i]) << (8*i);
            if (!u && nb < 4 && v[8*nb-1]) v |= ~((32'd1 << (8*nb)) - 32'd1);
            exp_rdata = v;
            e.lat = 2;
            e.nrd = 1;
        end else begin
            for (int i = 0; i < nb; i++) ref_b[a+i] = wd[8*i +: 8];
            e.lat = (nb == 4) ? 2 : 3;
            e.nrd = (nb == 4) ? 0 : 1;
            e.nwr = 1;
            e.wd  = word_of({a[31:2], 2'b00});
        end
        e.rdata = exp_rdata;
        return e;
    endfunction

    task automatic preload(input int idx, input logic [31:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_idx = 8'(idx); pre_data = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Drive one request and observe it; with spam, req stays high with a store while busy.
    task automatic do_req(input bit we, input bit [1:0] sz, input bit u, input bit [31:0] a,
                          input bit [31:0] wd, input bit spam, output obs_t o);
        int rd0, wr0, dn0, n;
        @(negedge clk);
        mif.req = 1'b1; mif.we = we; mif.size = sz; mif.uns = u; mif.addr = a; mif.wdata = wd;
        rd0 = rd_cnt; wr0 = wr_cnt; dn0 = done_cnt;
        @(posedge clk); #1;
        if (spam) begin
            mif.we = 1'b1; mif.size = 2'd2; mif.addr = 32'h20; mif.wdata = $urandom;
        end else mif.req = 1'b0;
        n = 1;
        while (mif.done !== 1'b1 && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        o.lat = n; o.err = mif.err; o.rdata = mif.rdata;
        @(posedge clk); #1;
        mif.req = 1'b0;
        o.nrd = rd_cnt - rd0; o.nwr = wr_cnt - wr0; o.ndone = done_cnt - dn0;
        o.wd = (wr_cnt != wr0) ? last_wd : 32'h0;
    endtask

    task automatic test_reset();
        for (int pass = 0; pass < 2; pass++) begin
            nvec++;
            if ({mif.busy, mif.done, mif.err, mif.mem_read, mif.mem_write} !== 5'b0) begin
                nmis++;
                $display("FAIL reset_ctrl[%0d]: got busy/done/err/rd/wr=%b, expected 00000", pass,
                         {mif.busy, mif.done, mif.err, mif.mem_read, mif.mem_write});
            end
            nvec++;
            if ({mif.rdata, mif.mem_addr, mif.mem_wd} !== 96'h0) begin
                nmis++;
                $display("FAIL reset_data[%0d]: got rdata=%h mem_addr=%h mem_wd=%h, expected all 0",
                         pass, mif.rdata, mif.mem_addr, mif.mem_wd);
            end
            if (pass == 0) begin
                @(negedge clk); rst_n = 1'b1;
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_word_load();
        obs_t e, o;
        e = model(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, o);
        nvec++;
        if (o !== e) begin
            nmis++; $display("FAIL word_load: got %s, expected %s", fmt(o), fmt(e));
        end
        nvec++;
        if (o.rdata !== 32'h80817F02) begin
            nmis++; $display("FAIL word_load_value: got %h, expected 80817f02", o.rdata);
        end
    endtask

    task automatic test_subword_loads();
        logic [31:0] ta [4] = '{32'h12, 32'h12, 32'h12, 32'h10};
        logic [1:0]  ts [4] = '{2'd0, 2'd0, 2'd1, 2'd1};
        logic        tu [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        obs_t e, o;
        for (int i = 0; i < 4; i++) begin
            e = model(1'b0, ts[i], tu[i], ta[i], 32'h0);
            do_req(1'b0, ts[i], tu[i], ta[i], 32'h0, 1'b0, o);
            nvec++;
            if (o !== e) begin
                nmis++; $display("FAIL subword_load[%0d]: got %s, expected %s", i, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_byte_store();
        obs_t e, o;
        e = model(1'b1, 2'd0, 1'b0, 32'h11, 32'h000000AA);
        do_req(1'b1, 2'd0, 1'b0, 32'h11, 32'h000000AA, 1'b0, o);
        nvec++;
        if (o !== e) begin
            nmis++; $display("FAIL byte_store: got %s, expected %s", fmt(o), fmt(e));
        end
        e = model(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, o);
        nvec++;
        if (o !== e) begin
            nmis++; $display("FAIL byte_store_readback: got %s, expected %s", fmt(o), fmt(e));
        end
    endtask

    task automatic test_rejects();
        logic [31:0] ta [4] = '{32'h11, 32'h13, 32'h10, 32'h400};
        logic [1:0]  ts [4] = '{2'd2, 2'd1, 2'd3, 2'd2};
        obs_t e, o;
        for (int i = 0; i < 4; i++) begin
            e = model(1'b0, ts[i], 1'b0, ta[i], 32'h0);
            do_req(1'b0, ts[i], 1'b0, ta[i], 32'h0, 1'b0, o);
            nvec++;
            if (o !== e) begin
                nmis++; $display("FAIL reject[%0d]: got %s, expected %s", i, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_busy_ignored();
        obs_t e, o;
        int   rd0, wr0, dn0;
        e = model(1'b0, 2'd0, 1'b0, 32'h10, 32'h0);
        do_req(1'b0, 2'd0, 1'b0, 32'h10, 32'h0, 1'b1, o);
        nvec++;
        if (o !== e) begin
            nmis++; $display("FAIL busy_lb: got %s, expected %s", fmt(o), fmt(e));
        end
        e = model(1'b0, 2'd2, 1'b1, 32'h14, 32'h0);
        do_req(1'b0, 2'd2, 1'b1, 32'h14, 32'h0, 1'b1, o);
        nvec++;
        if (o !== e) begin
            nmis++; $display("FAIL busy_lw: got %s, expected %s", fmt(o), fmt(e));
        end
        rd0 = rd_cnt; wr0 = wr_cnt; dn0 = done_cnt;
        repeat (5) @(posedge clk);
        #1;
        nvec++;
        if ({rd_cnt - rd0, wr_cnt - wr0, done_cnt - dn0} !== 96'h0 || mif.busy !== 1'b0) begin
            nmis++;
            $display("FAIL busy_quiet: got rd=%0d wr=%0d done=%0d busy=%b, expected 0 0 0 0",
                     rd_cnt - rd0, wr_cnt - wr0, done_cnt - dn0, mif.busy);
        end
    endtask

    task automatic test_reset_mid_store();
        int dn0, wr0;
        ref_b[16] = 8'h02; ref_b[17] = 8'h7F; ref_b[18] = 8'h81; ref_b[19] = 8'h80;
        preload(4, word_of(32'h10));
        dn0 = done_cnt; wr0 = wr_cnt;
        @(negedge clk);
        mif.req = 1'b1; mif.we = 1'b1; mif.size = 2'd2; mif.addr = 32'h10; mif.wdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        mif.req = 1'b0;
        nvec++;
        if (mif.mem_write !== 1'b1) begin
            nmis++; $display("FAIL rst_store_wr_state: got mem_write=%b, expected 1", mif.mem_write);
        end
        #1 rst_n = 1'b0;
        #1;
        nvec++;
        if ({mif.busy, mif.done, mif.err, mif.mem_read, mif.mem_write} !== 5'b0 ||
            {mif.rdata, mif.mem_addr, mif.mem_wd} !== 96'h0) begin
            nmis++;
            $display("FAIL rst_store_outputs: got ctrl=%b rdata=%h addr=%h wd=%h, expected all 0",
                     {mif.busy, mif.done, mif.err, mif.mem_read, mif.mem_write},
                     mif.rdata, mif.mem_addr, mif.mem_wd);
        end
        exp_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        nvec++;
        if (mem[4] !== word_of(32'h10) || wr_cnt != wr0 || done_cnt != dn0 || mif.busy !== 1'b0) begin
            nmis++;
            $display("FAIL rst_store_effect: got mem=%h writes=%0d dones=%0d busy=%b, expected mem=%h 0 0 0",
                     mem[4], wr_cnt - wr0, done_cnt - dn0, mif.busy, word_of(32'h10));
        end
    endtask

    task automatic test_random();
        obs_t        e, o;
        bit          we, u, spam;
        bit [1:0]    sz;
        bit [31:0]   a, wd;
        for (int i = 0; i < 60; i++) begin
            we = 1'($urandom); u = 1'($urandom); spam = 1'($urandom);
            sz = 2'($urandom_range(0, 3));
            wd = $urandom;
            case ($urandom_range(0, 7))
                0:       a = $urandom;
                1:       a = 32'($urandom_range(1014, 1030));
                default: a = 32'($urandom_range(0, 63));
            endcase
            e = model(we, sz, u, a, wd);
            do_req(we, sz, u, a, wd, spam, o);
            nvec++;
            if (o !== e) begin
                nmis++;
                $display("FAIL random[%0d] we=%0b sz=%0d uns=%0b addr=%h: got %s, expected %s",
                         i, we, sz, u, a, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_memory_image();
        int bad = 0;
        int first = -1;
        for (int w = 0; w < 256; w++) begin
            if (mem[w] !== word_of(32'(4*w))) begin
                bad++;
                if (first < 0) first = w;
            end
        end
        nvec++;
        if (bad != 0) begin
            nmis++;
            $display("FAIL memory_image: %0d words differ, first at word %0d: got %h, expected %h",
                     bad, first, mem[first], word_of(32'(4*first)));
        end
    endtask

    initial begin
        rst_n = 1'b0; pre_we = 1'b0; pre_idx = '0; pre_data = '0;
        mif.req = 1'b0; mif.we = 1'b0; mif.size = 2'd0; mif.uns = 1'b0;
        mif.addr = '0; mif.wdata = '0;
        exp_rdata = '0;
        for (int i = 0; i < 1024; i++) ref_b[i] = 8'($urandom);
        ref_b[16] = 8'h02; ref_b[17] = 8'h7F; ref_b[18] = 8'h81; ref_b[19] = 8'h80;
        for (int w = 0; w < 256; w++) preload(w, word_of(32'(4*w)));

        test_reset();
        test_word_load();
        test_subword_loads();
        test_byte_store();
        test_rejects();
        test_reset_mid_store();
        test_busy_ignored();
        test_random();
        test_memory_image();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
